// File: rtl/qpi_flash_pkg.sv
// Shared opcodes, encodings and types for the QPI flash responder.
package qpi_flash_pkg;

  localparam logic [7:0] OP_QPI_EXIT  = 8'hFF;
  localparam logic [7:0] OP_FAST_RD   = 8'h0B;
  localparam logic [7:0] OP_SET_PARAM = 8'hC0;
  localparam logic [7:0] OP_RST_EN    = 8'h66;
  localparam logic [7:0] OP_RST       = 8'h99;
  localparam logic [7:0] OP_QPI_EN    = 8'h38;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  localparam logic [3:0] DUMMY_DEF = 4'd2;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_PARAM,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE,
    ST_RSTWAIT
  } state_e;

  typedef enum logic {
    MODE_SPI,
    MODE_QPI
  } mode_e;

  // P[5:4] selects 2,4,6,8 dummy edges
  function automatic logic [3:0] dummy_dec(input logic [1:0] p);
    return {1'b0, p, 1'b0} + 4'd2;
  endfunction

  // P[1:0] selects an 8,16,32,64 byte wrap window
  function automatic logic [6:0] wrap_mask(input logic [1:0] sel);
    return (7'd8 << sel) - 7'd1;
  endfunction

endpackage

// File: rtl/qpi_resp_addr_gen.sv
// Read address register: loads the start address, then steps
// linearly or within the wrap window.
module qpi_resp_addr_gen
  import qpi_flash_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  input  logic              wrap_en_i,
  input  logic [1:0]        wrap_sel_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] inc;

  always_comb begin
    mask   = ADDR_W'(wrap_mask(wrap_sel_i));
    inc    = addr_q + ADDR_W'(1);
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      addr_d = wrap_en_i ? ((addr_q & ~mask) | (inc & mask)) : inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/qpi_flash_responder.sv
// QPI serial-flash device model serving Fast Read from a byte memory.
// Define QPIRESP_RDSR_EN to add QPI Read Status (0x05).
module qpi_flash_responder
  import qpi_flash_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int RST_CYC = 1800
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cs_n,
  input  logic              sclk_en,
  input  logic [3:0]        io_i,
  output logic [3:0]        io_o,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int RC_W = $clog2(RST_CYC + 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [23:0]       sh_q, sh_d, sh_nx;
  logic              armed_q, armed_d;
  logic [3:0]        dummy_q, dummy_d;
  logic              wrap_en_q, wrap_en_d;
  logic [1:0]        wrap_sel_q, wrap_sel_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [3:0]        io_o_q, io_o_d;
  logic [3:0]        io_oe_q, io_oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        buf_q, buf_d;
  logic [3:0]        cur_q, cur_d;
  logic              lo_nx_q, lo_nx_d;
  logic              rdsr_q, rdsr_d;
  logic              addr_ld, addr_inc, pres_hi, cmd_done;
  logic [7:0]        cmd, src;
`ifdef QPIRESP_RDSR_EN
  logic [7:0]        status;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    armed_d    = armed_q;
    dummy_d    = dummy_q;
    wrap_en_d  = wrap_en_q;
    wrap_sel_d = wrap_sel_q;
    rcnt_d     = rcnt_q;
    io_o_d     = io_o_q;
    io_oe_d    = io_oe_q;
    mem_rd_d   = 1'b0;
    rd_pend_d  = mem_rd_q;
    buf_d      = rd_pend_q ? mem_rdata : buf_q;
    cur_d      = cur_q;
    lo_nx_d    = lo_nx_q;
    rdsr_d     = rdsr_q;
    addr_ld    = 1'b0;
    addr_inc   = 1'b0;
    pres_hi    = 1'b0;
    // SPI only touches the low byte so the address bits ride through
    sh_nx = (mode_q == MODE_SPI) ? {sh_q[23:8], sh_q[6:0], io_i[0]}
                                 : {sh_q[19:0], io_i};
    cmd      = sh_nx[7:0];
    cmd_done = cnt_q == ((mode_q == MODE_SPI) ? 4'd7 : 4'd1);
    src      = rd_pend_q ? mem_rdata : buf_q;
`ifdef QPIRESP_RDSR_EN
    status = {7'b0, state_q == ST_RSTWAIT};
    if (rdsr_q) src = status;
`endif

    if (state_q == ST_RSTWAIT) begin
      if (rcnt_q == '0) begin
        state_d    = ST_CMD;
        mode_d     = MODE_SPI;
        dummy_d    = DUMMY_DEF;
        wrap_en_d  = 1'b0;
        wrap_sel_d = 2'd0;
        armed_d    = 1'b0;
        cnt_d      = '0;
      end else begin
        rcnt_d = rcnt_q - RC_W'(1);
      end
    end else if (cs_n) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      io_oe_d = '0;
      io_o_d  = '0;
      rdsr_d  = 1'b0;
      lo_nx_d = 1'b0;
    end else if (sclk_en) begin
      sh_d  = sh_nx;
      cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        ST_CMD: begin
          if (cmd_done) begin
            cnt_d   = '0;
            state_d = ST_IGNORE;
            if (mode_q == MODE_SPI) begin
              armed_d = (cmd == OP_RST_EN);
              if (cmd == OP_RST && armed_q) begin
                state_d = ST_RSTWAIT;
                rcnt_d  = RC_W'(RST_CYC - 1);
              end
              if (cmd == OP_QPI_EN) mode_d = MODE_QPI;
            end else begin
              unique case (1'b1)
                cmd == OP_QPI_EXIT:  mode_d  = MODE_SPI;
                cmd == OP_SET_PARAM: state_d = ST_PARAM;
                cmd == OP_FAST_RD:   state_d = ST_ADDR;
`ifdef QPIRESP_RDSR_EN
                cmd == OP_RDSR: begin
                  state_d = ST_DATA;
                  rdsr_d  = 1'b1;
                  io_o_d  = status[7:4];
                  cur_d   = status[3:0];
                  io_oe_d = 4'hF;
                  lo_nx_d = 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        ST_PARAM: begin
          if (cnt_q == 4'd1) begin
            dummy_d    = dummy_dec(sh_nx[5:4]);
            wrap_en_d  = (sh_nx[7:6] == 2'd0);
            wrap_sel_d = sh_nx[1:0];
            state_d    = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (cnt_q == 4'd5) begin
            addr_ld  = 1'b1;
            mem_rd_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_DUMMY;
          end
        end
        ST_DUMMY: begin
          if (cnt_q == dummy_q - 4'd1) begin
            state_d = ST_DATA;
            pres_hi = 1'b1;
          end
        end
        ST_DATA: begin
          if (lo_nx_q) begin
            io_o_d  = cur_q;
            lo_nx_d = 1'b0;
          end else begin
            pres_hi = 1'b1;
          end
        end
        default: ;
      endcase
      // presenting a high nibble also fetches the following byte
      if (pres_hi) begin
        io_o_d  = src[7:4];
        cur_d   = src[3:0];
        io_oe_d = 4'hF;
        lo_nx_d = 1'b1;
        if (!rdsr_q) begin
          mem_rd_d = 1'b1;
          addr_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_CMD;
      mode_q     <= MODE_SPI;
      cnt_q      <= '0;
      sh_q       <= '0;
      armed_q    <= 1'b0;
      dummy_q    <= DUMMY_DEF;
      wrap_en_q  <= 1'b0;
      wrap_sel_q <= 2'd0;
      rcnt_q     <= '0;
      io_o_q     <= '0;
      io_oe_q    <= '0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      buf_q      <= '0;
      cur_q      <= '0;
      lo_nx_q    <= 1'b0;
      rdsr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      armed_q    <= armed_d;
      dummy_q    <= dummy_d;
      wrap_en_q  <= wrap_en_d;
      wrap_sel_q <= wrap_sel_d;
      rcnt_q     <= rcnt_d;
      io_o_q     <= io_o_d;
      io_oe_q    <= io_oe_d;
      mem_rd_q   <= mem_rd_d;
      rd_pend_q  <= rd_pend_d;
      buf_q      <= buf_d;
      cur_q      <= cur_d;
      lo_nx_q    <= lo_nx_d;
      rdsr_q     <= rdsr_d;
    end
  end

  qpi_resp_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .load_i     (addr_ld),
    .load_addr_i(ADDR_W'(sh_nx)),
    .inc_i      (addr_inc),
    .wrap_en_i  (wrap_en_q),
    .wrap_sel_i (wrap_sel_q),
    .addr_o     (mem_addr)
  );

  assign io_o   = io_o_q;
  assign io_oe  = io_oe_q;
  assign mem_rd = mem_rd_q;
  assign busy   = (state_q == ST_RSTWAIT);

endmodule

// File: tb/tb_qpi_flash_responder.sv
// Scoreboard bench for qpi_flash_responder; backing memory holds mem[i]=i[7:0].
module tb_qpi_flash_responder;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cs_n;
  logic        sclk_en;
  logic [3:0]  io_i;
  logic [3:0]  io_o;
  logic [3:0]  io_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int gap = 1;
  int busy_cyc = 0;
  logic oe_seen = 1'b0;
  logic [3:0] expq[$];

  bit w_en = 1'b0;
  int w_len = 8;
  int tb_dummy = 2;

  always #5 HCLK = ~HCLK;

  qpi_flash_responder #(
    .ADDR_W(24),
    .RST_CYC(1800)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .cs_n     (cs_n),
    .sclk_en  (sclk_en),
    .io_i     (io_i),
    .io_o     (io_o),
    .io_oe    (io_oe),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always @(posedge HCLK) if (mem_rd) mem_rdata <= mem_addr[7:0];

  always @(posedge HCLK) if (busy === 1'b1) busy_cyc++;

  always @(negedge HCLK) if (io_oe !== 4'h0) oe_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every flash edge with drivers on must match the next entry
  always @(posedge HCLK) begin : mon
    logic fe;
    logic [3:0] e;
    fe = !cs_n && sclk_en && !HRESET;
    #1;
    if (fe && io_oe === 4'hF) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_nibble: got %0h, expected none", io_o);
      end else begin
        e = expq.pop_front();
        check("data_nibble", {28'd0, io_o}, {28'd0, e});
      end
    end
  end

  task automatic fedge(input logic [3:0] n);
    io_i = n;
    sclk_en = 1'b1;
    @(negedge HCLK);
    sclk_en = 1'b0;
    io_i = 4'h0;
    repeat (gap) @(negedge HCLK);
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic cs_hi();
    cs_n = 1'b1;
    sclk_en = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic spi_frame(input logic [7:0] b);
    cs_lo();
    for (int i = 7; i >= 0; i--) fedge({3'b0, b[i]});
    cs_hi();
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    fedge(b[7:4]);
    fedge(b[3:0]);
  endtask

  task automatic qpi_param(input logic [7:0] p);
    cs_lo();
    qpi_byte(8'hC0);
    qpi_byte(p);
    cs_hi();
  endtask

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    logic [23:0] m;
    m = 24'(w_len - 1);
    if (w_en) return (a & ~m) | ((a + 24'd1) & m);
    return a + 24'd1;
  endfunction

  task automatic push_exp(input logic [23:0] a, input int nnib);
    logic [23:0] x;
    logic [7:0] b;
    x = a;
    for (int k = 0; k < nnib; k++) begin
      b = x[7:0];
      expq.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
      if (k % 2 == 1) x = next_addr(x);
    end
  endtask

  task automatic fr_head(input logic [23:0] a);
    cs_lo();
    qpi_byte(8'h0B);
    for (int k = 5; k >= 0; k--) fedge(a[4*k +: 4]);
  endtask

  task automatic fast_read(input logic [23:0] a, input int nnib,
                           input bit exp_on);
    if (exp_on) push_exp(a, nnib);
    fr_head(a);
    repeat (tb_dummy + nnib - 1) fedge(4'h0);
    cs_hi();
    check("oe_after_cs", {28'd0, io_oe}, 32'd0);
    check("queue_drained", expq.size(), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1;
    cs_n = 1'b1;
    sclk_en = 1'b0;
    io_i = 4'h0;
    repeat (3) @(negedge HCLK);
    check("rst_io_o", {28'd0, io_o}, 32'd0);
    check("rst_io_oe", {28'd0, io_oe}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // an intervening opcode disarms the reset sequence
    spi_frame(8'h66);
    spi_frame(8'h05);
    spi_frame(8'h99);
    check("disarmed_busy", {31'd0, busy}, 32'd0);

    spi_frame(8'h66);
    busy_cyc = 0;
    spi_frame(8'h99);
    check("busy_rise", {31'd0, busy}, 32'd1);
    spi_frame(8'h38);
    for (int i = 0; i < 4000 && busy; i++) @(negedge HCLK);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("busy_cycles", busy_cyc, 32'd1800);

    oe_seen = 1'b0;
    fast_read(24'h000100, 4, 1'b0);
    check("spi_after_reset_oe", {31'd0, oe_seen}, 32'd0);

    spi_frame(8'h38);
    qpi_param(8'h30);
    tb_dummy = 8; w_en = 1'b1; w_len = 8;
    fast_read(24'h000100, 12, 1'b1);

    qpi_param(8'h03);
    tb_dummy = 2; w_en = 1'b1; w_len = 64;
    gap = 0;
    fast_read(24'h00003C, 32, 1'b1);
    gap = 1;

    qpi_param(8'h40);
    tb_dummy = 2; w_en = 1'b0;
    fast_read(24'h00003C, 32, 1'b1);
    fast_read(24'hFFFFFE, 8, 1'b1);

    fast_read(24'h0000A5, 5, 1'b1);
    fast_read(24'h000200, 4, 1'b1);

    oe_seen = 1'b0;
`ifdef QPIRESP_RDSR_EN
    for (int i = 0; i < 8; i++) expq.push_back(4'h0);
`endif
    cs_lo();
    qpi_byte(8'h05);
    repeat (7) fedge(4'h0);
    cs_hi();
`ifdef QPIRESP_RDSR_EN
    check("rdsr_drained", expq.size(), 32'd0);
`else
    check("rdsr_off_oe", {31'd0, oe_seen}, 32'd0);
`endif

    cs_lo();
    qpi_byte(8'hFF);
    cs_hi();
    oe_seen = 1'b0;
    fast_read(24'h000100, 4, 1'b0);
    check("spi_after_ff_oe", {31'd0, oe_seen}, 32'd0);

    spi_frame(8'h38);
    push_exp(24'h000300, 4);
    fr_head(24'h000300);
    repeat (tb_dummy + 3) fedge(4'h0);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("hrst_io_o", {28'd0, io_o}, 32'd0);
    check("hrst_io_oe", {28'd0, io_oe}, 32'd0);
    check("hrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("hrst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("hrst_busy", {31'd0, busy}, 32'd0);
    check("hrst_drained", expq.size(), 32'd0);
    HRESET = 1'b0;
    cs_hi();

    // defaults after reset: dummy=2, linear addressing
    spi_frame(8'h38);
    tb_dummy = 2; w_en = 1'b0;
    fast_read(24'h00007E, 8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
